// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM encoding and
// iteration count.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MULT_ITER = 8;

endpackage

// File: rtl/carrySellect8.sv
// 8-bit carry-select adder: the low nibble ripples, and the high nibble is
// precomputed for both carry values and then selected by the low carry-out.
module carrySellect8 (
  input  logic [7:0] inp1,
  input  logic [7:0] inp2,
  input  logic       carryIn,
  output logic [7:0] sum,
  output logic       carryOut
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, inp1[3:0]} + {1'b0, inp2[3:0]} + {4'b0, carryIn};
    hi0 = {1'b0, inp1[7:4]} + {1'b0, inp2[7:4]};
    hi1 = {1'b0, inp1[7:4]} + {1'b0, inp2[7:4]} + 5'd1;
  end

  assign sum      = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign carryOut = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned shift-add multiplier built around carrySellect8.
// It does one add-and-shift per clock and has a start/busy/done handshake.
module seq_mult8
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_ITER - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign addend = mq[0] ? mcand : '0;

  carrySellect8 u_adder (
    .inp1     (acc),
    .inp2     (addend),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (cout)
  );

  // The adder carry-out becomes the new MSB of acc, so nothing is lost on the
  // right shift and the 16-bit product is always exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= {cout, sum[WIDTH-1:1]};
          mq    <= {sum[0], mq[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            // The product register is loaded on the final iteration, so it
            // holds its value through IDLE even after acc/mq are recaptured.
            product <= {cout, sum, mq[WIDTH-1:1]};
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_mult8.sv
// Directed self-checking bench for seq_mult8: reset, products, ignored start,
// back-to-back restart and asynchronous reset mid-run.
module tb_seq_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total = 0;
  int bad   = 0;

  seq_mult8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a one-cycle start pulse; returns at the negedge after the capture edge.
  task automatic pulse_start(input logic [7:0] ta, input logic [7:0] tb_);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after capture: checks 8 busy cycles, then done and product.
  // If stray_at >= 0 a start pulse with a=b=7 is injected during RUN.
  task automatic run_and_check(input string name, input logic [15:0] exp, input int stray_at);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s run cyc%0d: busy=%b done=%b required busy=1 done=0", name, i, busy, done);
      end
      if (i == stray_at) begin
        start = 1'b1; a = 8'd7; b = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse: done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    total++;
    if (product !== exp) begin
      bad++;
      $display("FAIL %s product: got %h required %h", name, product, exp);
    end
  endtask

  // Called at the DONE negedge with start low: done must drop and product must hold.
  task automatic check_idle_hold(input string name, input logic [15:0] exp);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
        bad++;
        $display("FAIL %s idle_hold: done=%b busy=%b product=%h required 0 0 %h",
                 name, done, busy, product, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    pulse_start(8'd199, 8'd55);
    a = 8'd0; b = 8'd0;  // operand changes after capture must have no effect
    run_and_check("m199x55", 16'h2AC1, -1);
    check_idle_hold("m199x55", 16'h2AC1);
  endtask

  task automatic test_products();
    pulse_start(8'd255, 8'd255);
    run_and_check("m255x255", 16'hFE01, -1);
    check_idle_hold("m255x255", 16'hFE01);
    pulse_start(8'd0, 8'd173);
    run_and_check("m0x173", 16'h0000, -1);
    check_idle_hold("m0x173", 16'h0000);
    pulse_start(8'd100, 8'd1);
    run_and_check("m100x1", 16'h0064, -1);
    check_idle_hold("m100x1", 16'h0064);
  endtask

  task automatic test_ignore_start();
    pulse_start(8'd5, 8'd89);
    run_and_check("ign5x89", 16'h01BD, 3);
    check_idle_hold("ign5x89", 16'h01BD);
  endtask

  task automatic test_back_to_back();
    pulse_start(8'd3, 8'd4);
    run_and_check("b2b_first", 16'h000C, -1);
    a = 8'd12; b = 8'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: done=%b busy=%b required done=0 busy=1", done, busy);
    end
    run_and_check("b2b_second", 16'h0090, -1);
    check_idle_hold("b2b_second", 16'h0090);
  endtask

  task automatic test_async_reset();
    pulse_start(8'd199, 8'd55);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      bad++;
      $display("FAIL after_release: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
    end
    pulse_start(8'd2, 8'd3);
    run_and_check("m2x3", 16'h0006, -1);
    check_idle_hold("m2x3", 16'h0006);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
